led7_scan_ctrl: RTL and testbench
=================================

# led7_scan_ctrl

Time-multiplexed scan controller for the door lock's multi-digit 7-segment display. It sits directly upstream of `led7_decoder`. Each scan slot it selects one 4-bit digit from a packed input bus, drives that digit into the decoder's `i_binary`/`i_en`, and asserts the matching common-anode select. It also provides per-digit blanking, per-digit blinking (for the cursor or entry position) and anti-ghosting dead time between digits.

## Interface
- `N_DIGITS`, 4: number of display digits; must be ≥ 2.
- `REFRESH_DIV`, 50000: clock cycles per digit slot; must be > `DEAD_CYCLES`.
- `DEAD_CYCLES`, 2: cycles at the start of each slot during which all anodes are off; must be ≥ 1.
- `BLINK_SCANS`, 64: complete scans per blink half-period; must be ≥ 1.

Ports:
- `i_clk` in 1: system clock; all state is updated on the rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_digits` in 4*N_DIGITS: packed digit values; digit k is `[4k+3:4k]`; digit 0 is the rightmost.
- `i_digit_en` in N_DIGITS: per-digit enable; 0 blanks that digit.
- `i_blink_mask` in N_DIGITS: 1 makes that digit blink.
- `o_binary` out 4: digit value; connects to the decoder's `i_binary`.
- `o_en` out 1: segment enable; connects to the decoder's `i_en`.
- `o_anode` out N_DIGITS: active-low, one-hot-or-all-ones digit select.
- `o_scan_done` out 1: one-cycle pulse at the end of each full scan.

## Operation
- Internal state:
  - `cnt`: slot counter, 0..REFRESH_DIV-1.
  - `idx`: digit index, 0..N_DIGITS-1.
  - `scan_cnt`: 0..BLINK_SCANS-1.
  - `blink_ph`: blink phase, 1 bit.
  - Per-slot FSM with two states, `DEAD` and `DRIVE`.
- Reset (asynchronous, any time, including mid-slot):
  - `cnt`=0, `idx`=0, `scan_cnt`=0, `blink_ph`=0, state=`DEAD`.
  - `o_anode`=all 1s, `o_en`=0, `o_binary`=0, `o_scan_done`=0.
- `cnt` increments every cycle and wraps from REFRESH_DIV-1 to 0. On that wrap:
  - `idx` advances, wrapping from N_DIGITS-1 to 0.
  - State returns to `DEAD`.
- `DEAD` → `DRIVE` when `cnt` reaches DEAD_CYCLES-1 (at the next edge). `DRIVE` is held until the slot wraps.
- Slot start:
  - `i_digits[idx]` and `i_digit_en[idx]` are snapshotted into `o_binary` and an internal enable.
  - Input changes mid-slot have no effect until the next slot of that digit (no tearing).
- In `DEAD`: `o_anode`=all 1s, `o_en`=0.
- In `DRIVE`:
  - `o_anode` = all 1s except bit `idx` = 0.
  - `o_en` = snapshot_en AND NOT(`i_blink_mask[idx]` AND `blink_ph`).
  - Blink is sampled live, so a mask change takes effect on the next cycle.
- Scan completion, on the wrap that moves `idx` from N_DIGITS-1 to 0:
  - `o_scan_done` = 1 for exactly one cycle.
  - `scan_cnt` increments; when it wraps from BLINK_SCANS-1 to 0, `blink_ph` toggles.
- A blanked digit still consumes its slot, so the refresh rate is constant. Its anode is still driven, but `o_en`=0, so the decoder outputs all segments off.
- `o_binary` is never driven to X or high-Z; it holds the last snapshot.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Cycle 0 is the first rising edge after `i_rst_n` deasserts. Slot s occupies cycles s·REFRESH_DIV … s·REFRESH_DIV+REFRESH_DIV-1.
- Per slot:
  - `o_binary` updates at the slot's first edge.
  - `o_anode` is all 1s for DEAD_CYCLES cycles, then the digit is selected for REFRESH_DIV−DEAD_CYCLES cycles.
- `o_scan_done` is high during the last cycle of slot N_DIGITS-1 of every scan.
- Full scan period = N_DIGITS·REFRESH_DIV cycles. Blink period = 2·BLINK_SCANS scans.
- Two anodes are never low in the same cycle. Between any two consecutive selections there are ≥ DEAD_CYCLES all-off cycles.

## Test plan
All scenarios use N_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2, BLINK_SCANS=2.

- **Reset/rotation.** Stimulus: `i_digits`=16'h4321, all enabled, no blink, release reset. Required:
  - `o_anode` = 1111 for cycles 0–1, then 1110 for cycles 2–7, then 1111, then 1101, and so on.
  - `o_binary` = 1, 2, 3, 4 in successive slots.
  - `o_en`=1 only in `DRIVE`.
  - `o_scan_done` high only in cycle 31.
- **Blanking.** Stimulus: `i_digit_en`=4'b1011. Required:
  - Digit 2's slot still runs with `o_anode`=1011.
  - `o_en`=0 for that whole slot.
- **Blink.** Stimulus: `i_blink_mask`=4'b0001. Required:
  - Digit 0 has `o_en`=1 in scans 0–1.
  - `o_en`=0 in scans 2–3.
  - `o_en`=1 again in scans 4–5.
- **Snapshot.** Stimulus: change `i_digits[3:0]` from 1 to 9 at cycle 4. Required:
  - `o_binary` stays 1 through cycle 7.
  - It shows 9 at the next digit-0 slot (cycle 32).
- **Mid-operation reset.** Stimulus: assert `i_rst_n`=0 at cycle 13. Required:
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - After release, the sequence restarts from digit 0 with a `DEAD` phase.
- **Dead-time invariant.** Stimulus: random `i_digits` and `i_digit_en` over 1000 cycles. Required:
  - `o_anode` always has at most one 0.
  - Every anode transition passes through ≥ 2 cycles of 1111.

Source files
------------

// File: rtl/led7_scan_ctrl_if.sv
// led7_scan_ctrl_if: digit inputs and decoder/anode outputs of the 7-segment scan controller
interface led7_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] i_digits;
  logic [N_DIGITS-1:0]   i_digit_en;
  logic [N_DIGITS-1:0]   i_blink_mask;
  logic [3:0]            o_binary;
  logic                  o_en;
  logic [N_DIGITS-1:0]   o_anode;
  logic                  o_scan_done;
  modport master (
    output i_digits, i_digit_en, i_blink_mask,
    input  o_binary, o_en, o_anode, o_scan_done
  );
  modport slave (
    input  i_digits, i_digit_en, i_blink_mask,
    output o_binary, o_en, o_anode, o_scan_done
  );
endinterface

// File: rtl/led7_scan_ctrl.sv
// led7_scan_ctrl: time-multiplexed 7-segment digit scanner with blanking, blinking and dead time
module led7_scan_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2,
  parameter int BLINK_SCANS = 64
) (
  input logic             i_clk,
  input logic             i_rst_n,
  led7_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam int SW = BLINK_SCANS > 1 ? $clog2(BLINK_SCANS) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_END = CW'(DEAD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(N_DIGITS - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(BLINK_SCANS - 1);
  typedef enum logic {DEAD, DRIVE} state_t;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [SW-1:0]       scan_q, scan_d;
  logic                blink_ph_q, blink_ph_d;
  logic                snap_en_q, snap_en_d;
  logic [3:0]          binary_q, binary_d;
  logic                en_q, en_d;
  logic [N_DIGITS-1:0] anode_q, anode_d;
  logic                scan_done_q, scan_done_d;
  logic                slot_end, scan_end;
  // outputs register a function of the current slot state, so they lag it by one edge
  always_comb begin
    slot_end    = cnt_q == CNT_MAX;
    scan_end    = slot_end && idx_q == IDX_MAX;
    cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
    idx_d       = slot_end ? (idx_q == IDX_MAX ? '0 : idx_q + 1'b1) : idx_q;
    scan_d      = scan_end ? (scan_q == SCAN_MAX ? '0 : scan_q + 1'b1) : scan_q;
    blink_ph_d  = blink_ph_q ^ (scan_end && scan_q == SCAN_MAX);
    state_d     = slot_end ? DEAD : (cnt_q == DEAD_END ? DRIVE : state_q);
    binary_d    = cnt_q == '0 ? bus.i_digits[{idx_q, 2'b00} +: 4] : binary_q;
    snap_en_d   = cnt_q == '0 ? bus.i_digit_en[idx_q] : snap_en_q;
    anode_d     = state_q == DRIVE ? ~(N_DIGITS'(1) << idx_q) : '1;
    en_d        = state_q == DRIVE && snap_en_q && !(bus.i_blink_mask[idx_q] && blink_ph_q);
    scan_done_d = scan_end;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= DEAD;
      cnt_q       <= '0;
      idx_q       <= '0;
      scan_q      <= '0;
      blink_ph_q  <= 1'b0;
      snap_en_q   <= 1'b0;
      binary_q    <= '0;
      en_q        <= 1'b0;
      anode_q     <= '1;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      scan_q      <= scan_d;
      blink_ph_q  <= blink_ph_d;
      snap_en_q   <= snap_en_d;
      binary_q    <= binary_d;
      en_q        <= en_d;
      anode_q     <= anode_d;
      scan_done_q <= scan_done_d;
    end
  end
  assign bus.o_binary    = binary_q;
  assign bus.o_en        = en_q;
  assign bus.o_anode     = anode_q;
  assign bus.o_scan_done = scan_done_q;
endmodule

// File: tb/tb_led7_scan_ctrl.sv
// tb_led7_scan_ctrl: cycle-count reference model plus literal spot checks for led7_scan_ctrl
module tb_led7_scan_ctrl;
  localparam int N = 4, R = 8, D = 2, B = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_pass = 0, n_total = 0, cyc = 0, gap = 0;
  int m_cnt, m_slot, m_idx;
  logic m_ph, snap_en, e_en, e_done;
  logic [3:0] snap_bin, e_anode, prev_a = 4'hF;
  led7_scan_ctrl_if #(.N_DIGITS(N)) bus();
  led7_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .BLINK_SCANS(B)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
  endtask
  // reference: everything follows from the cycle number since reset release
  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0;
      gap = 0;
      prev_a = 4'hF;
      #1;
      check("rst_anode", 32'(bus.o_anode), 32'hF);
      check("rst_en", 32'(bus.o_en), 32'h0);
      check("rst_binary", 32'(bus.o_binary), 32'h0);
      check("rst_done", 32'(bus.o_scan_done), 32'h0);
    end else begin
      m_cnt  = cyc % R;
      m_slot = cyc / R;
      m_idx  = m_slot % N;
      m_ph   = ((m_slot / N) / B) % 2 == 1;
      if (m_cnt == 0) begin
        snap_bin = bus.i_digits[4*m_idx +: 4];
        snap_en  = bus.i_digit_en[m_idx];
      end
      e_anode = m_cnt < D ? 4'hF : ~(4'b1 << m_idx);
      e_en    = m_cnt >= D && snap_en && !(bus.i_blink_mask[m_idx] && m_ph);
      e_done  = m_cnt == R - 1 && m_idx == N - 1;
      #1;
      check("model_anode", 32'(bus.o_anode), 32'(e_anode));
      check("model_en", 32'(bus.o_en), 32'(e_en));
      check("model_binary", 32'(bus.o_binary), 32'(snap_bin));
      check("model_done", 32'(bus.o_scan_done), 32'(e_done));
      check("one_anode_max", 32'($countones(~bus.o_anode) <= 1), 32'h1);
      if (bus.o_anode == 4'hF) gap++;
      else begin
        if (bus.o_anode != prev_a) check("dead_gap", 32'(gap >= D), 32'h1);
        gap = 0;
      end
      prev_a = bus.o_anode;
      cyc++;
    end
  end
  initial begin
    bus.i_digits     = 16'h4321;
    bus.i_digit_en   = 4'hF;
    bus.i_blink_mask = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #2;
      if (c == 0 || c == 1) check("lit_anode_dead0", 32'(bus.o_anode), 32'hF);
      if (c == 1) check("lit_en_dead0", 32'(bus.o_en), 32'h0);
      if (c == 2 || c == 7) check("lit_anode_d0", 32'(bus.o_anode), 32'hE);
      if (c == 2) check("lit_en_d0", 32'(bus.o_en), 32'h1);
      if (c == 2 || c == 7) check("lit_bin_d0", 32'(bus.o_binary), 32'h1);
      if (c == 8) check("lit_anode_dead1", 32'(bus.o_anode), 32'hF);
      if (c == 8) check("lit_bin_d1", 32'(bus.o_binary), 32'h2);
      if (c == 10) check("lit_anode_d1", 32'(bus.o_anode), 32'hD);
      if (c == 24) check("lit_bin_d3", 32'(bus.o_binary), 32'h4);
      if (c == 26) check("lit_anode_d3", 32'(bus.o_anode), 32'h7);
      if (c == 30) check("lit_done_30", 32'(bus.o_scan_done), 32'h0);
      if (c == 31) check("lit_done_31", 32'(bus.o_scan_done), 32'h1);
      if (c == 32) check("lit_bin_snap9", 32'(bus.o_binary), 32'h9);
      if (c == 42) check("lit_en_d1_on", 32'(bus.o_en), 32'h1);
      if (c == 50) check("lit_anode_blank", 32'(bus.o_anode), 32'hB);
      if (c == 50 || c == 55) check("lit_en_blank", 32'(bus.o_en), 32'h0);
      if (c == 66) check("lit_anode_blink", 32'(bus.o_anode), 32'hE);
      if (c == 66 || c == 98) check("lit_en_blink_off", 32'(bus.o_en), 32'h0);
      if (c == 74) check("lit_en_noblink_d1", 32'(bus.o_en), 32'h1);
      if (c == 130) check("lit_en_blink_on", 32'(bus.o_en), 32'h1);
      @(negedge clk);
      if (c == 4) bus.i_digits = 16'h4329;
      if (c == 39) bus.i_digit_en = 4'b1011;
      if (c == 55) bus.i_blink_mask = 4'b0001;
    end
    bus.i_digit_en   = 4'hF;
    bus.i_blink_mask = 4'h0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #2;
      if (c == 13) check("lit_anode_pre_rst", 32'(bus.o_anode), 32'hD);
    end
    #1 rst_n = 1'b0;
    #1;
    check("lit_async_anode", 32'(bus.o_anode), 32'hF);
    check("lit_async_en", 32'(bus.o_en), 32'h0);
    check("lit_async_binary", 32'(bus.o_binary), 32'h0);
    check("lit_async_done", 32'(bus.o_scan_done), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #2;
      if (c < 2) check("lit_restart_dead", 32'(bus.o_anode), 32'hF);
      if (c == 2) check("lit_restart_d0", 32'(bus.o_anode), 32'hE);
      if (c == 2) check("lit_restart_bin", 32'(bus.o_binary), 32'h9);
    end
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      bus.i_digits     = 16'($urandom);
      bus.i_digit_en   = 4'($urandom);
      bus.i_blink_mask = 4'($urandom);
    end
    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
